// File: rtl/control_comptador_pkg.sv
// control_comptador_pkg: shared widths, mode constants and FSM state encoding
package control_comptador_pkg;
  localparam int CNT_W = 8;
  localparam int PRESC_W = 4;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/comptador_8_bits.sv
// comptador_8_bits: 8-bit up-counter with asynchronous clear and count enable
//   clk in  : clock, rising edge
//   rst in  : asynchronous clear, active-high
//   en  in  : advance by one on the next edge
//   out out : current count
module comptador_8_bits
  import control_comptador_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] out
);
  logic [CNT_W-1:0] out_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else if (en) out_q <= out_q + 1'b1;
  end
  assign out = out_q;
endmodule

// File: rtl/control_comptador.sv
// control_comptador: start/stop sequencer driving a prescaled 8-bit counter up to a terminal value
//   clk   in  : clock, rising edge
//   rst   in  : asynchronous reset, active-high
//   start in  : launch request, honoured only when idle
//   stop  in  : abort request, honoured whenever busy
//   mode  in  : 0 one-shot, 1 periodic
//   limit in  : terminal count
//   presc in  : counter advances once every presc+1 cycles
//   count out : counter value
//   busy  out : sequence in progress
//   done  out : one-cycle pulse when the terminal count is reached
module control_comptador
  import control_comptador_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic               mode_q, mode_d, clr_q, done_q;
  logic               accept, tick, at_limit, cnt_en, cnt_rst;
  assign accept   = (state_q == IDLE) && start && !stop;
  assign tick     = pcnt_q == presc_q;
  assign at_limit = count == limit_q;
  // gating on at_limit keeps the counter parked at the terminal value
  assign cnt_en   = (state_q == RUN) && tick && !at_limit;
  // clr comes straight from a flop so the counter's async clear is glitch-free
  assign cnt_rst  = rst | clr_q;
  assign limit_d  = accept ? limit : limit_q;
  assign presc_d  = accept ? presc : presc_q;
  assign mode_d   = accept ? mode : mode_q;
  assign pcnt_d   = (state_q == RUN) ? (tick ? '0 : pcnt_q + 1'b1) : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? CLEAR : IDLE;
      CLEAR:   state_d = stop ? IDLE : RUN;
      RUN:     state_d = stop ? IDLE : (at_limit ? DONE : RUN);
      default: state_d = (stop || mode_q != MODE_PERIODIC) ? IDLE : CLEAR;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      limit_q <= '0;
      presc_q <= '0;
      mode_q  <= MODE_ONESHOT;
      pcnt_q  <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      pcnt_q  <= pcnt_d;
      clr_q   <= state_d == CLEAR;
      done_q  <= state_d == DONE;
    end
  end
  comptador_8_bits u_cnt (
    .clk(clk),
    .rst(cnt_rst),
    .en (cnt_en),
    .out(count)
  );
  assign busy = state_q != IDLE;
  assign done = done_q;
endmodule
